// File: rtl/bitmap_pixel_shifter.sv
// ---------------------------------------------------------------------------
// bitmap_pixel_shifter
//
// Serialises 16-bit bitmap words (four 4-bit pixels) from video RAM into a
// 4-bit pixel index stream at half the system clock rate. It also applies
// horizontal flip, 0-3 pixel fine scroll and blanking, and raises a sticky
// flag when the pixel supply runs dry during active video.
//
// Ports
//   CLK10     in   1   10 MHz system clock (the only clock)
//   RESET     in   1   synchronous, active-high reset
//   LOAD      in   1   load VD into the shifter (sampled on strobe edges)
//   VD        in   16  bitmap word, pixel 0 = VD[15:12], pixel 3 = VD[3:0]
//   FLIP      in   1   horizontal flip, captured together with LOAD
//   HSCRL     in   2   fine scroll, extra output delay of 0-3 pixels
//   BLANK     in   1   forces BIT to 0 and masks underrun detection
//   PIXEN     out  1   pixel phase, high in the cycle before each strobe edge
//   BIT       out  4   pixel colour index to the colour memory
//   UNDERRUN  out  1   sticky starvation flag, cleared only by RESET
// ---------------------------------------------------------------------------
module bitmap_pixel_shifter (
    input  logic        CLK10,
    input  logic        RESET,
    input  logic        LOAD,
    input  logic [15:0] VD,
    input  logic        FLIP,
    input  logic [1:0]  HSCRL,
    input  logic        BLANK,
    output logic        PIXEN,
    output logic [3:0]  BIT,
    output logic        UNDERRUN
);

    logic        r_ph;
    logic [15:0] r_sr;
    logic        r_fr;
    logic [2:0]  r_avail;
    logic [3:0]  r_tap [0:3];
    logic [3:0]  r_bit;
    logic        r_underrun;

    logic        w_have;
    logic [3:0]  w_cur;
    logic [3:0]  w_tap_in;
    logic [15:0] w_sr_shift;
    logic [3:0]  w_tap_sel;

    // The pixel leaving the shifter sits at whichever end the word was
    // loaded for: MSB nibble normally, LSB nibble when flipped.
    assign w_have     = (r_avail != 3'd0);
    assign w_cur      = r_fr ? r_sr[3:0] : r_sr[15:12];
    assign w_tap_in   = w_have ? w_cur : 4'h0;
    assign w_sr_shift = r_fr ? {4'h0, r_sr[15:4]} : {r_sr[11:0], 4'h0};
    // Old tap contents: the scroll read sees the line before this edge's shift.
    assign w_tap_sel  = r_tap[HSCRL];

    always_ff @(posedge CLK10) begin
        if (RESET) begin
            r_ph       <= 1'b0;
            r_sr       <= 16'h0000;
            r_fr       <= 1'b0;
            r_avail    <= 3'd0;
            r_tap[0]   <= 4'h0;
            r_tap[1]   <= 4'h0;
            r_tap[2]   <= 4'h0;
            r_tap[3]   <= 4'h0;
            r_bit      <= 4'h0;
            r_underrun <= 1'b0;
        end else begin
            r_ph <= ~r_ph;
            // Strobe edge: every other clock, where the pixel state advances.
            if (r_ph) begin
                r_tap[0] <= w_tap_in;
                r_tap[1] <= r_tap[0];
                r_tap[2] <= r_tap[1];
                r_tap[3] <= r_tap[2];

                if (!w_have && !BLANK) begin
                    r_underrun <= 1'b1;
                end

                // A load wins over the shift; leftover pixels are dropped.
                if (LOAD) begin
                    r_sr    <= VD;
                    r_fr    <= FLIP;
                    r_avail <= 3'd4;
                end else if (w_have) begin
                    r_sr    <= w_sr_shift;
                    r_avail <= r_avail - 3'd1;
                end

                r_bit <= BLANK ? 4'h0 : w_tap_sel;
            end
        end
    end

    assign PIXEN    = r_ph;
    assign BIT      = r_bit;
    assign UNDERRUN = r_underrun;

endmodule

// File: tb/tb_bitmap_pixel_shifter.sv
// ---------------------------------------------------------------------------
// tb_bitmap_pixel_shifter
//
// Directed bench for bitmap_pixel_shifter: reset behaviour, streaming with and
// without flip, fine scroll latency, underrun detection and clearing,
// blanking mid-word and reset in the middle of a word.
// ---------------------------------------------------------------------------
module tb_bitmap_pixel_shifter;

    logic        CLK10;
    logic        RESET;
    logic        LOAD;
    logic [15:0] VD;
    logic        FLIP;
    logic [1:0]  HSCRL;
    logic        BLANK;
    logic        PIXEN;
    logic [3:0]  BIT;
    logic        UNDERRUN;

    int n_vec;
    int n_err;

    bitmap_pixel_shifter dut (
        .CLK10    (CLK10),
        .RESET    (RESET),
        .LOAD     (LOAD),
        .VD       (VD),
        .FLIP     (FLIP),
        .HSCRL    (HSCRL),
        .BLANK    (BLANK),
        .PIXEN    (PIXEN),
        .BIT      (BIT),
        .UNDERRUN (UNDERRUN)
    );

    initial CLK10 = 1'b0;
    always #5 CLK10 = ~CLK10;

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    // Advance through the next strobe edge; returns 1 time unit after it.
    task automatic strobe();
        int n;
        n = 0;
        while (PIXEN !== 1'b1 && n < 4) begin
            @(posedge CLK10); #1;
            n++;
        end
        if (PIXEN !== 1'b1) begin
            $display("FAIL strobe_wait: PIXEN observed %b required 1", PIXEN);
            $fatal(1, "no strobe phase seen");
        end
        @(posedge CLK10); #1;
    endtask

    task automatic do_reset(input string tag);
        RESET = 1'b1;
        @(posedge CLK10); #1;
        RESET = 1'b0;
        LOAD  = 1'b0;
        BLANK = 1'b1;
        HSCRL = 2'd0;
        FLIP  = 1'b0;
        chk1({tag, "_pixen"}, PIXEN, 1'b0);
        chk4({tag, "_bit"}, BIT, 4'h0);
        chk1({tag, "_underrun"}, UNDERRUN, 1'b0);
    endtask

    // Two back-to-back words loaded at strobes k and k+4; index i = strobe k+i.
    task automatic run_stream(input logic flip, input logic toggle, input string tag);
        logic [3:0] exp [0:7];
        for (int j = 0; j < 8; j++) begin
            if (!flip) exp[j] = 4'(j + 1);
            else if (j < 4) exp[j] = 4'(4 - j);
            else exp[j] = 4'(12 - j);
        end
        for (int i = 0; i < 10; i++) begin
            LOAD  = (i == 0 || i == 4);
            VD    = (i == 0) ? 16'h1234 : 16'h5678;
            BLANK = (i == 0);
            HSCRL = 2'd0;
            FLIP  = (toggle && i == 2) ? ~flip : flip;
            strobe();
            if (i == 1) chk4({tag, "_bit_pre"}, BIT, 4'h0);
            if (i >= 2) chk4({tag, "_bit"}, BIT, exp[i-2]);
            if (i <= 8) chk1({tag, "_underrun"}, UNDERRUN, 1'b0);
        end
        LOAD = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        RESET = 1'b1;
        LOAD  = 1'b0;
        VD    = 16'h0000;
        FLIP  = 1'b0;
        HSCRL = 2'd0;
        BLANK = 1'b1;
        repeat (2) @(posedge CLK10);
        #1;

        // Idle after reset: blanked, no load, no underrun, phase 0 then 1.
        do_reset("rst");
        @(posedge CLK10); #1;
        chk1("pixen_first_edge", PIXEN, 1'b1);
        for (int i = 0; i < 20; i++) begin
            strobe();
            chk1("idle_pixen", PIXEN, 1'b0);
            chk4("idle_bit", BIT, 4'h0);
            chk1("idle_underrun", UNDERRUN, 1'b0);
        end

        // Gapless streaming, plain and flipped, and flip toggled mid-word.
        do_reset("rst_s0");
        run_stream(1'b0, 1'b0, "stream");
        do_reset("rst_s1");
        run_stream(1'b1, 1'b0, "stream_flip");
        do_reset("rst_s2");
        run_stream(1'b1, 1'b1, "stream_fliptog");

        // Fine scroll 3: pixel 0 after k+5.
        do_reset("rst_h3");
        for (int i = 0; i < 7; i++) begin
            LOAD  = (i == 0);
            VD    = 16'hABCD;
            BLANK = (i == 0);
            HSCRL = 2'd3;
            strobe();
            if (i == 4) chk4("hscrl3_pre", BIT, 4'h0);
            if (i == 5) chk4("hscrl3_p0", BIT, 4'hA);
            if (i == 6) chk4("hscrl3_p1", BIT, 4'hB);
        end

        // Fine scroll 1: pixel 0 after k+3.
        do_reset("rst_h1");
        for (int i = 0; i < 5; i++) begin
            LOAD  = (i == 0);
            VD    = 16'hABCD;
            BLANK = (i == 0);
            HSCRL = 2'd1;
            strobe();
            if (i == 2) chk4("hscrl1_pre", BIT, 4'h0);
            if (i == 3) chk4("hscrl1_p0", BIT, 4'hA);
            if (i == 4) chk4("hscrl1_p1", BIT, 4'hB);
        end

        // Single word then starvation: underrun set at k+5, cleared by reset.
        do_reset("rst_u");
        for (int i = 0; i < 7; i++) begin
            LOAD  = (i == 0);
            VD    = 16'h1234;
            BLANK = (i == 0);
            HSCRL = 2'd0;
            strobe();
            if (i >= 2 && i <= 5) chk4("single_bit", BIT, 4'(i - 1));
            if (i == 4) chk1("single_ur_k4", UNDERRUN, 1'b0);
            if (i == 5) chk1("single_ur_k5", UNDERRUN, 1'b1);
            if (i == 6) begin
                chk4("single_bit_k6", BIT, 4'h0);
                chk1("single_ur_k6", UNDERRUN, 1'b1);
            end
        end
        do_reset("rst_uclr");

        // Blanking for strobes k+3 and k+4 of an all-F word.
        for (int i = 0; i < 6; i++) begin
            LOAD  = (i == 0);
            VD    = 16'hFFFF;
            BLANK = (i == 0 || i == 3 || i == 4);
            HSCRL = 2'd0;
            strobe();
            if (i == 2) chk4("blank_k2", BIT, 4'hF);
            if (i == 3) chk4("blank_k3", BIT, 4'h0);
            if (i == 4) begin
                chk4("blank_k4", BIT, 4'h0);
                chk1("blank_ur_k4", UNDERRUN, 1'b0);
            end
            if (i == 5) chk4("blank_k5", BIT, 4'hF);
        end

        // Reset mid-word: the in-flight word is lost, so the shifter starves.
        do_reset("rst_m");
        for (int i = 0; i < 3; i++) begin
            LOAD  = (i == 0);
            VD    = 16'h1234;
            BLANK = (i == 0);
            strobe();
        end
        chk4("midword_bit", BIT, 4'h1);
        do_reset("rst_mid");
        BLANK = 1'b0;
        strobe();
        chk4("after_rst_bit0", BIT, 4'h0);
        chk1("after_rst_ur", UNDERRUN, 1'b1);
        strobe();
        chk4("after_rst_bit1", BIT, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
